gshare_index_unit: RTL

- Sits directly upstream of the pattern history table (PHT): generates the gshare index `pht_idx` from the fetch PC and a speculative global history register (GHR).
- Records each prediction in an in-order in-flight FIFO, so the execute-stage update index (`EX_pht_idx`) and `load` strobe reach the PHT unchanged.
- Repairs speculative history on mispredict or flush.

---
 rtl/gshare_index_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/gshare_index_unit.sv
// Gshare index generator with speculative/committed global history and an
// in-order in-flight FIFO that carries each prediction to its resolve point.
module gshare_index_unit #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IF_valid,
    input  logic [31:0]      IF_pc,
    input  logic             pht_prediction,
    output logic [IDX_W-1:0] pht_idx,
    output logic             IF_stall,
    input  logic             EX_resolve,
    input  logic             EX_branch_flag,
    input  logic             flush,
    output logic [IDX_W-1:0] EX_pht_idx,
    output logic             load,
    output logic             mispredict
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [IDX_W-1:0] spec_ghr;
    logic [IDX_W-1:0] commit_ghr;
    logic [IDX_W-1:0] commit_ghr_next;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] fifo_idx  [DEPTH];
    logic             fifo_pred [DEPTH];

    logic has_entry;
    logic pop;
    logic repair;
    logic accept;

    always_comb begin
        pht_idx    = IF_pc[IDX_W+1:2] ^ spec_ghr;
        IF_stall   = (count == FULL);
        has_entry  = (count != '0);
        pop        = EX_resolve && has_entry;
        load       = pop;
        EX_pht_idx = has_entry ? fifo_idx[rd_ptr] : '0;
        mispredict = pop && (fifo_pred[rd_ptr] != EX_branch_flag);
        repair     = mispredict || flush;
        accept     = IF_valid && !IF_stall && !repair;
        commit_ghr_next = pop ? {commit_ghr[IDX_W-2:0], EX_branch_flag} : commit_ghr;
    end

    // Repair rewinds speculative history to the committed history including
    // this cycle's resolve, and empties the FIFO by snapping rd onto wr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_ghr   <= '0;
            commit_ghr <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            commit_ghr <= commit_ghr_next;
            if (repair) begin
                count    <= '0;
                rd_ptr   <= wr_ptr;
                spec_ghr <= commit_ghr_next;
            end else begin
                if (accept) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    spec_ghr <= {spec_ghr[IDX_W-2:0], pht_prediction};
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (accept && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !accept) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_idx[wr_ptr]  <= pht_idx;
            fifo_pred[wr_ptr] <= pht_prediction;
        end
    end

endmodule
